// File: rtl/diaosi_types_pkg.sv
// Shared types for the memory arbiter: arbitration states and the
// default anti-starvation limit.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    I_ACC = 2'd1,
    D_ACC = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_STARVE_LIMIT = 4;
  localparam int unsigned ARB_CNT_W        = 3;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data-side grants taken while the icache waits;
// raises force_i once the limit is reached so the icache wins next.
module arb_starve_ctr
  import diaosi_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input  logic CLK,
  input  logic nRST,
  input  logic iREN,
  input  logic grant_d,
  input  logic grant_i,
  output logic force_i
);

  logic [ARB_CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (!iREN || grant_i) begin
      cnt <= '0;
    end else if (grant_d && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_i = iREN && (32'(cnt) >= STARVE_LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache; data side wins by default.
// Define ARB_STARVE_GUARD_EN to bound how long a pending icache read can wait.
module mem_arbiter
  import diaosi_types_pkg::*;
#(
`ifdef ARB_STARVE_GUARD_EN
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
`endif
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready
);

  arb_state_t state, next_state;
  logic       force_i;

`ifdef ARB_STARVE_GUARD_EN
  logic grant_d, grant_i;

  assign grant_d = (state == IDLE) && (next_state == D_ACC);
  assign grant_i = (state == IDLE) && (next_state == I_ACC);

  arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .CLK    (CLK),
    .nRST   (nRST),
    .iREN   (iREN),
    .grant_d(grant_d),
    .grant_i(grant_i),
    .force_i(force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (force_i)           next_state = I_ACC;
        else if (dREN || dWEN) next_state = D_ACC;
        else if (iREN)         next_state = I_ACC;
      end
      I_ACC: begin
        if (ramready || !iREN) next_state = IDLE;
      end
      D_ACC: begin
        if (ramready || !(dREN || dWEN)) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      I_ACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramready) begin
          iwait = 1'b0;
          iload = ramload;
        end
      end
      D_ACC: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
        if (ramready) begin
          dwait = 1'b0;
          if (!dWEN) dload = ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction cache and the data cache.
- Sits between the cache layer (icache fetch port, dcache fill/writeback port) and the memory/RAM model.
- Grants one requester per transaction, holds the grant until RAM completes, and returns data and wait signalling to the winner.
- Data side has priority by default; an optional anti-starvation guard bounds icache waiting.

Parameters:
- STARVE_LIMIT, 4, consecutive data-side grants tolerated while iREN is pending before the icache is forced to win (used only with ARB_STARVE_GUARD_EN).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  icache wait; 0 only in the completion cycle.
- iload  out  32  icache read data; valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  dcache wait; 0 only in the completion cycle.
- dload  out  32  dcache read data; valid when dwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM completes the current access this cycle.

Behaviour:
- Reset state and IDLE outputs: state=IDLE; iwait=dwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0; iload=dload=0; starvation counter=0. Reset mid-transaction abandons the access; RAM strobes drop asynchronously.
- States: IDLE, I_ACC, D_ACC.
- IDLE arbitration, evaluated once per cycle:
  - If dREN|dWEN, go to D_ACC; else if iREN, go to I_ACC; else stay in IDLE.
  - No RAM strobes are driven in IDLE, giving a 1-cycle arbitration bubble.
- I_ACC:
  - Drive ramREN=1, ramWEN=0, ramaddr=iaddr.
  - When ramready=1: iwait=0 and iload=ramload combinationally in that cycle; next state IDLE.
  - If iREN drops before ramready: abort, next state IDLE, iwait stays 1.
- D_ACC:
  - Drive ramaddr=daddr.
  - dWEN=1 gives ramWEN=1, ramREN=0, ramstore=dstore; dWEN has precedence when dREN and dWEN are both 1.
  - Otherwise ramREN=1.
  - When ramready=1: dwait=0, dload=ramload (reads; dload=0 for writes); next state IDLE.
  - If dREN and dWEN both drop before ramready: abort to IDLE, dwait stays 1.
- Latency:
  - Request asserted in cycle N gives the earliest completion (wait=0) in cycle N+1.
  - Back-to-back requests from the same side complete at least 2 cycles apart (IDLE bubble).
- The non-granted side always sees wait=1 and load=0.
- ramready observed in IDLE is ignored.
- Address and data are passed through unmodified; no width conversion.
- Requesters must hold address and data stable while wait=1. The arbiter samples them combinationally and does not latch them.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit saturating counter increments on each IDLE->D_ACC transition taken while iREN=1.
  - It clears on IDLE->I_ACC, or in any cycle where iREN=0.
  - When counter >= STARVE_LIMIT and iREN=1 in IDLE, the arbiter goes to I_ACC even if dREN|dWEN=1.
- Undefined: strict data-side priority; counter logic is absent.

Decomposition:
- diaosi_types_pkg gains:
  - arb_state_t enum {IDLE, I_ACC, D_ACC}.
  - Default constant ARB_STARVE_LIMIT=4.
- Sub-module arb_starve_ctr holds the counter and the force_i output. It is instantiated only under ARB_STARVE_GUARD_EN.

Test Plan:
- Reset with all requests low, then idle 3 cycles -> iwait=dwait=1, ramREN=ramWEN=0, ramaddr=0 throughout.
- iREN=1, iaddr=0x40, ramload=0x8C010004, ramready after 2 cycles in I_ACC -> ramREN=1 with ramaddr=0x40; iwait=0 and iload=0x8C010004 in exactly one cycle; then state IDLE.
- iREN=1 and dWEN=1 asserted in the same cycle, daddr=0x100, dstore=0xDEADBEEF -> D_ACC first (ramWEN=1, ramstore=0xDEADBEEF); icache is served next with iwait=1 until then.
- dREN and dWEN both 1 -> ramWEN=1, ramREN=0; completion gives dwait=0 and dload=0.
- dREN drops after 1 cycle in D_ACC with no ramready -> return to IDLE, dwait never 0; a pending iREN is granted next.
- With ARB_STARVE_GUARD_EN: dREN held high continuously and iREN high -> after 4 data grants, the 5th grant goes to I_ACC; without the macro, the icache never completes.
